programmable_lut: RTL and testbench

PROGRAMMABLE_LUT -- requirements
Module: programmable_lut

---
 rtl/programmable_lut.sv | 137 +++++++++++++
 tb/tb_programmable_lut.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/programmable_lut.sv
// rtl/programmable_lut.sv - serially loaded N_IN-input truth-table lookup with valid handshake
//
// Purpose: holds a 2^N_IN-bit truth table loaded one bit per cycle (first bit
// loaded lands in entry 0). Once the load completes, each accepted input pattern
// is looked up and returned one cycle later with out_valid.
//
// Optional feature macro: LUT_FILTER_EN. When defined, out only moves to a new
// value after FILTER_CYCLES consecutive accepted inputs look up that new value.
//
// Ports:
//   clk        - clock, all state on rising edge
//   rst        - synchronous active-high reset
//   in         - input pattern, in[N_IN-1] is the index MSB
//   in_valid   - input pattern valid
//   in_ready   - input can be accepted this cycle (combinational)
//   cfg_start  - begin (or restart) a truth-table load
//   cfg_bit    - serial truth-table bit
//   cfg_valid  - cfg_bit valid
//   cfg_done   - one-cycle pulse after the last table bit is accepted
//   out        - looked-up (optionally filtered) result
//   out_valid  - out carries the result of the input accepted last cycle
module programmable_lut #(
  parameter int N_IN          = 3,
  parameter int FILTER_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            cfg_start,
  input  logic            cfg_bit,
  input  logic            cfg_valid,
  output logic            cfg_done,
  output logic            out,
  output logic            out_valid
);

  localparam int TT_BITS = 2 ** N_IN;

  // Elaboration-time legality check of the configuration.
  if (N_IN < 1 || N_IN > 6 || FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_param_check
    $error("programmable_lut: N_IN must be 1..6 and FILTER_CYCLES 1..15");
  end

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t               state_q;
  logic [TT_BITS-1:0]   tt_q;
  logic [N_IN-1:0]      cnt_q;
  logic                 out_q;
  logic                 out_valid_q;
  logic                 cfg_done_q;
  logic                 accept;
  logic                 lookup_d;

`ifdef LUT_FILTER_EN
  localparam logic [3:0] FC_LAST = 4'(FILTER_CYCLES - 1);
  logic [3:0]           run_q;
`endif

  // cfg_start and reset both take priority over a new input, so the input
  // presented alongside either is simply never accepted.
  assign in_ready  = (state_q == RUN) && !cfg_start && !rst;
  assign accept    = in_valid && in_ready;
  assign lookup_d  = tt_q[in];

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign cfg_done  = cfg_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNCFG;
      tt_q        <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_done_q  <= 1'b0;
`ifdef LUT_FILTER_EN
      run_q       <= 4'd0;
`endif
    end else begin
      out_valid_q <= accept;
      cfg_done_q  <= 1'b0;

`ifdef LUT_FILTER_EN
      // run_q counts consecutive acceptances disagreeing with out; since out
      // is one bit, every disagreeing lookup proposes the same new value.
      if (accept) begin
        if (lookup_d == out_q) begin
          run_q <= 4'd0;
        end else if (run_q == FC_LAST) begin
          out_q <= lookup_d;
          run_q <= 4'd0;
        end else begin
          run_q <= run_q + 4'd1;
        end
      end
`else
      if (accept) begin
        out_q <= lookup_d;
      end
`endif

      if (cfg_start) begin
        // Restart from bit 0; bits already written are overwritten by the
        // new load before the table can be used again.
        state_q <= LOAD;
        cnt_q   <= '0;
`ifdef LUT_FILTER_EN
        run_q   <= 4'd0;
`endif
      end else begin
        case (state_q)
          LOAD: begin
            if (cfg_valid) begin
              tt_q[cnt_q] <= cfg_bit;
              cnt_q       <= cnt_q + 1'b1;
              if (cnt_q == {N_IN{1'b1}}) begin
                state_q    <= RUN;
                cfg_done_q <= 1'b1;
              end
            end
          end
          RUN:     state_q <= RUN;
          default: state_q <= UNCFG;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_programmable_lut.sv
// tb/tb_programmable_lut.sv - self-checking bench for programmable_lut
module tb_programmable_lut;

  localparam int N  = 3;
  localparam int FC = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] in_pat = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         cfg_start = 1'b0;
  logic         cfg_bit = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_done;
  logic         out;
  logic         out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  programmable_lut #(.N_IN(N), .FILTER_CYCLES(FC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_pat),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cfg_start (cfg_start),
    .cfg_bit   (cfg_bit),
    .cfg_valid (cfg_valid),
    .cfg_done  (cfg_done),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Reference model: configured flag, a queue of bits received in the
  // current load, and the table formed from that queue once it is full.
  bit          m_cfg;
  bit          m_loading;
  bit          m_bits[$];
  bit [7:0]    m_tt;
  bit          m_out;
  bit          m_ov;
  bit          m_done;
  int          m_run;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cfg = 0; m_loading = 0; m_bits.delete(); m_tt = '0;
    m_out = 0; m_ov = 0; m_done = 0; m_run = 0;
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
  task automatic cyc(input bit r, input bit cs, input bit cb, input bit cv,
                     input bit iv, input bit [N-1:0] pat);
    bit exp_rdy;
    bit acc;
    bit lk;
    rst = r; cfg_start = cs; cfg_bit = cb; cfg_valid = cv; in_valid = iv; in_pat = pat;
    #1;
    exp_rdy = m_cfg && !cs && !r;
    chk("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    acc = iv && exp_rdy;
    if (r) begin
      model_reset();
    end else begin
      m_ov = acc;
      m_done = 0;
      if (acc) begin
        lk = m_tt[pat];
`ifdef LUT_FILTER_EN
        if (lk == m_out) m_run = 0;
        else begin
          m_run++;
          if (m_run >= FC) begin m_out = lk; m_run = 0; end
        end
`else
        m_out = lk;
`endif
      end
      if (cs) begin
        m_cfg = 0; m_loading = 1; m_bits.delete(); m_run = 0;
      end else if (m_loading && cv) begin
        m_bits.push_back(cb);
        if (m_bits.size() == (1 << N)) begin
          for (int k = 0; k < (1 << N); k++) m_tt[k] = m_bits[k];
          m_loading = 0; m_cfg = 1; m_done = 1;
        end
      end
    end
    #1;
    chk("out", out, m_out);
    chk("out_valid", out_valid, m_ov);
    chk("cfg_done", cfg_done, m_done);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, '0);
  endtask

  // Load a table given as hex, bits presented MSB-first.
  task automatic load(input bit [7:0] hexv);
    cyc(0, 1, 0, 0, 0, '0);
    for (int i = 7; i >= 0; i--) cyc(0, 0, hexv[i], 1, 0, '0);
    chk("cfg_done_pulse", cfg_done, 1'b1);
    idle();
    chk("cfg_done_single", cfg_done, 1'b0);
  endtask

  typedef struct {
    bit         iv;
    bit [N-1:0] pat;
    bit         ov;
    bit         o;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 3'b001, 1, 0};
    tbl[1] = '{0, 3'b000, 0, 0};
    tbl[2] = '{1, 3'b011, 1, 1};
    tbl[3] = '{0, 3'b000, 0, 1};
    tbl[4] = '{1, 3'b000, 1, 1};
    tbl[5] = '{0, 3'b000, 0, 1};
    tbl[6] = '{1, 3'b010, 1, 0};
    tbl[7] = '{1, 3'b101, 1, 1};
    tbl[8] = '{1, 3'b010, 1, 0};
    tbl[9] = '{0, 3'b000, 0, 0};

    model_reset();
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, '0);

    // No table loaded: inputs are never accepted.
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 1, 3'(i));
      chk("uncfg_ready", in_ready, 1'b0);
      chk("uncfg_ov", out_valid, 1'b0);
      chk("uncfg_out", out, 1'b0);
    end

    load(8'h9F);

`ifndef LUT_FILTER_EN
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, tbl[i].iv, tbl[i].pat);
      chk("tbl_ov", out_valid, tbl[i].ov);
      chk("tbl_out", out, tbl[i].o);
    end
`else
    cyc(0, 0, 0, 0, 1, 3'b000);
    cyc(0, 0, 0, 0, 1, 3'b000);
    chk("flt_init", out, 1'b1);
    cyc(0, 0, 0, 0, 1, 3'b001); chk("flt_0", out, 1'b1);
    cyc(0, 0, 0, 0, 1, 3'b000); chk("flt_1", out, 1'b1);
    cyc(0, 0, 0, 0, 1, 3'b001); chk("flt_2", out, 1'b1);
    cyc(0, 0, 0, 0, 1, 3'b001); chk("flt_3", out, 1'b0);
    idle();
`endif

    // Interrupted load followed by a full all-ones load.
    cyc(0, 1, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, '0);
    load(8'hFF);
    for (int p = 0; p < 8; p++) begin
      cyc(0, 0, 0, 0, 1, 3'(p));
      cyc(0, 0, 0, 0, 1, 3'(p));
      chk("ff_out", out, 1'b1);
    end
    idle();

    // cfg_start wins over a simultaneous input.
    cyc(0, 1, 0, 0, 1, 3'b010);
    chk("drop_ov", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0, '0);

    // Reset on the fifth bit of a load.
    cyc(1, 0, 1, 1, 0, '0);
    cyc(0, 0, 0, 0, 1, 3'b111);
    chk("rst_ready", in_ready, 1'b0);
    cyc(0, 0, 0, 0, 1, 3'b111);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_out", out, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 249) == 0), ($urandom_range(0, 39) == 0),
          1'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
          3'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
